// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Initiator side of the data-memory interface. Accepts one RV32I load/store
// at a time, drives a word-organised memory (combinational read, write on
// rising clk), performs sub-word extraction with sign/zero extension for
// loads, and read-modify-write for SB/SH since the memory only writes whole
// words.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     request handshake (ready only while IDLE)
//   req_write           1 = store, 0 = load
//   req_funct3          RV32I funct3 (B/H/W/BU/HU)
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_error          misaligned access or illegal funct3
//   mem_addr            word address to memory (bits [1:0] = 00)
//   mem_write_enable    write strobe
//   mem_write_data      full word to write
//   mem_read_data       combinational read of word at mem_addr
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_enable,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        STORE  = 3'd3,
        RESP   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [2:0]            funct3_reg;
    logic [31:0]           data_reg;    // store data, later the merged word
    logic [31:0]           rdata_reg;   // extended load result

    logic        accept;
    logic        req_illegal;
    logic        req_misaligned;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign accept = req_valid && req_ready;

    // Request checks are evaluated on the raw request; they only steer the
    // next state out of IDLE, never the memory outputs.
    always_comb begin
        if (req_write)
            req_illegal = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) &&
                          (req_funct3 != 3'b010);
        else
            req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111);
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_illegal || req_misaligned)
                        state_next = ERR;
                    else if (!req_write)
                        state_next = LOAD;
                    else if (req_funct3[1])
                        state_next = STORE;     // SW needs no merge
                    else
                        state_next = RMW_RD;
                end
            end
            LOAD:    state_next = RESP;
            RMW_RD:  state_next = STORE;
            STORE:   state_next = RESP;
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: memory outputs depend only on state and latched fields
    always_comb begin
        req_ready        = (state_reg == IDLE) && !rst;
        resp_valid       = 1'b0;
        resp_error       = 1'b0;
        resp_rdata       = '0;
        mem_addr         = '0;
        mem_write_enable = 1'b0;
        mem_write_data   = '0;
        case (state_reg)
            LOAD, RMW_RD: begin
                mem_addr = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
            end
            STORE: begin
                mem_addr         = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
                mem_write_enable = 1'b1;
                mem_write_data   = data_reg;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_reg;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_error = 1'b1;
            end
            default: ;
        endcase
    end

    // Load extraction from the addressed lane
    assign byte_val = mem_read_data[{addr_reg[1:0], 3'b000} +: 8];
    assign half_val = mem_read_data[{addr_reg[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = {{24{byte_val[7]}}, byte_val};
            3'b001:  load_ext = {{16{half_val[15]}}, half_val};
            3'b100:  load_ext = {24'd0, byte_val};
            3'b101:  load_ext = {16'd0, half_val};
            default: load_ext = mem_read_data;
        endcase
    end

    // Merge per byte lane: funct3[0] distinguishes SH from SB in RMW_RD.
    // A halfword store places wdata[7:0] in the even lane and wdata[15:8]
    // in the odd lane; a byte store always uses wdata[7:0].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            logic lane_hit;
            assign lane_hit = funct3_reg[0] ? (addr_reg[1] == 1'(gi / 2))
                                            : (addr_reg[1:0] == 2'(gi));
            assign merged[8*gi +: 8] = !lane_hit      ? mem_read_data[8*gi +: 8] :
                                       funct3_reg[0]  ? data_reg[8*(gi % 2) +: 8] :
                                                        data_reg[7:0];
        end
    endgenerate

    // Latched request fields and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg   <= '0;
            funct3_reg <= '0;
            data_reg   <= '0;
            rdata_reg  <= '0;
        end else begin
            if (accept) begin
                addr_reg   <= req_addr;
                funct3_reg <= req_funct3;
                data_reg   <= req_wdata;
                rdata_reg  <= '0;
            end else if (state_reg == LOAD) begin
                rdata_reg <= load_ext;
            end else if (state_reg == RMW_RD) begin
                data_reg <= merged;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Word memory attached to the DUT, a behavioural reference (word array plus
// arithmetic sub-word rules and latency table) tracking every accepted
// request, a per-cycle compare process, and directed transactions with
// hand-computed expectations followed by a randomized stream with req_valid
// held high.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic [AW-1:0] mem_addr;
    logic          mem_write_enable;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory environment: 64 words covering byte addresses 0..255
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    assign mem_read_data = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_write_enable) mem[mem_addr[7:2]] <= mem_write_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic bit model_err(input logic w, input logic [2:0] f3, input logic [1:0] a);
        bit illegal, misal;
        if (w) illegal = (f3 > 3'd2);
        else   illegal = (f3 == 3'd3) || (f3 >= 3'd6);
        misal = ((f3 % 4 == 1) && (a % 2 != 0)) || ((f3 % 4 == 2) && (a != 0));
        return illegal || misal;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] a);
        logic [31:0] b, h;
        b = (word >> (8 * a)) & 32'hFF;
        h = (word >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] mask;
        if (f3 == 3'd2) return wd;
        mask = (f3 == 3'd0) ? (32'hFF << (8 * a)) : (32'hFFFF << (8 * a));
        return (old & ~mask) | ((wd << (8 * a)) & mask);
    endfunction

    // ---------------- per-cycle compare process ----------------
    bit          pend = 0;
    int          p_resp, p_we;
    logic [31:0] p_rdata, p_waddr, p_wdata;
    bit          p_err;

    always @(negedge clk) begin
        bit resp_exp, we_exp, e;
        int a_cyc, lat;
        logic [1:0] lo;
        if (rst) begin
            pend = 0;
        end else begin
            resp_exp = pend && (cyc == p_resp);
            we_exp   = pend && (cyc == p_we);
            check("req_ready", 32'(req_ready), 32'(!pend));
            check("resp_valid", 32'(resp_valid), 32'(resp_exp));
            check("mem_write_enable", 32'(mem_write_enable), 32'(we_exp));
            if (resp_exp) begin
                check("resp_rdata", resp_rdata, p_rdata);
                check("resp_error", 32'(resp_error), 32'(p_err));
                pend = 0;
            end
            if (we_exp) begin
                check("mem_addr", mem_addr, p_waddr);
                check("mem_write_data", mem_write_data, p_wdata);
            end
            if (req_valid && req_ready) begin
                a_cyc = cyc + 1;                 // acceptance happens at next edge
                lo    = req_addr[1:0];
                e     = model_err(req_write, req_funct3, lo);
                p_err   = e;
                p_rdata = 32'd0;
                p_we    = -1;
                if (e)                      lat = 1;
                else if (!req_write)        lat = 2;
                else if (req_funct3 == 3'd2) lat = 2;
                else                        lat = 3;
                if (!e && !req_write)
                    p_rdata = model_load(ref_mem[req_addr[7:2]], req_funct3, lo);
                if (!e && req_write) begin
                    p_we    = a_cyc + lat - 2;
                    p_waddr = req_addr & 32'hFFFF_FFFC;
                    p_wdata = model_store(ref_mem[req_addr[7:2]], req_wdata, req_funct3, lo);
                    ref_mem[req_addr[7:2]] = p_wdata;
                end
                p_resp = a_cyc + lat - 1;
                pend   = 1;
            end
        end
    end

    // ---------------- directed transaction driver ----------------
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat);
        int  a_cyc;
        bit  got;
        rd = 32'd0; err = 1'b0; lat = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout addr=0x%08h: got no req_ready, expected acceptance", addr);
            req_valid = 1'b0;
            return;
        end
        a_cyc = cyc + 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1;
                lat = cyc - a_cyc + 1;
                rd  = resp_rdata;
                err = resp_error;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL resp_timeout addr=0x%08h: got no resp_valid, expected a response", addr);
        end
    endtask

    task automatic txn(input string name, input logic w, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        err;
        int          lat;
        do_req(w, f3, addr, wd, rd, err, lat);
        $display("txn %-10s w=%0d f3=%03b addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
                 name, w, f3, addr, wd, rd, err, lat);
        check({name, ".rdata"}, rd, exp_rd);
        check({name, ".error"}, 32'(err), 32'(exp_err));
        check({name, ".latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_error", 32'(resp_error), 32'd0);
        check("rst.mem_we", 32'(mem_write_enable), 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_wdata", mem_write_data, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_release.req_ready", 32'(req_ready), 32'd1);

        // Directed: store / load round trip, RMW, sub-word loads, errors
        txn("SW", 1'b1, 3'b010, 32'h2C, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        check("mem[0x2C]_after_SW", mem[11], 32'hDEADBEEF);
        txn("LW", 1'b0, 3'b010, 32'h2C, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        txn("SW2", 1'b1, 3'b010, 32'h2C, 32'h11223344, 32'h0, 1'b0, 2);
        txn("SB", 1'b1, 3'b000, 32'h2D, 32'h000000AA, 32'h0, 1'b0, 3);
        check("mem[0x2C]_after_SB", mem[11], 32'h1122AA44);
        txn("LB", 1'b0, 3'b000, 32'h2D, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
        txn("LBU", 1'b0, 3'b100, 32'h2D, 32'h0, 32'h000000AA, 1'b0, 2);
        txn("LH", 1'b0, 3'b001, 32'h2E, 32'h0, 32'h00001122, 1'b0, 2);
        txn("LHU", 1'b0, 3'b101, 32'h2C, 32'h0, 32'h0000AA44, 1'b0, 2);
        txn("SH", 1'b1, 3'b001, 32'h2E, 32'h0000BEEF, 32'h0, 1'b0, 3);
        check("mem[0x2C]_after_SH", mem[11], 32'hBEEFAA44);
        txn("ERR_LW", 1'b0, 3'b010, 32'h2E, 32'h0, 32'h0, 1'b1, 1);
        txn("ERR_SH", 1'b1, 3'b001, 32'h2F, 32'h5555, 32'h0, 1'b1, 1);
        txn("ERR_F3", 1'b0, 3'b011, 32'h2C, 32'h0, 32'h0, 1'b1, 1);
        txn("ERR_SBU", 1'b1, 3'b100, 32'h2C, 32'h77, 32'h0, 1'b1, 1);
        check("mem[0x2C]_after_errors", mem[11], 32'hBEEFAA44);

        // Reset during STORE with req_valid held high
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(negedge clk);                       // idle: accepted at next edge
        @(posedge clk);                       // now in STORE
        #2 rst = 1'b1;
        #1;
        check("midrst.mem_we", 32'(mem_write_enable), 32'd0);
        check("midrst.resp_valid", 32'(resp_valid), 32'd0);
        check("midrst.req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        ref_mem[16] = mem[16];                // outcome of the aborted write is unspecified
        @(negedge clk);
        check("midrst_release.req_ready", 32'(req_ready), 32'd1);
        $display("txn MIDRST    store 0x40 aborted by reset");

        // Randomized stream with req_valid held high; fields change every cycle
        @(posedge clk); #1;
        req_valid = 1'b1;
        for (int i = 0; i < 800; i++) begin
            req_write  = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = 32'($urandom_range(0, 255));
            req_wdata  = $urandom;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 64; i++)
            check($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the core's memory stage.
- Drives the word-organised data memory: byte address, write_enable, write_data, combinational read_data, write on rising clk.
- Performs RV32I sub-word extraction and sign/zero extension for loads.
- Performs read-modify-write for SB/SH, because the memory only writes full words.

Parameters:
ADDR_WIDTH, 32, width of request and memory byte addresses

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  core presents a request
req_ready  output  1  unit can accept a request (IDLE only)
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_error  output  1  valid with resp_valid: misaligned or illegal funct3
mem_addr  output  ADDR_WIDTH  word address to memory, bits [1:0] = 00
mem_write_enable  output  1  write strobe, memory writes on rising clk
mem_write_data  output  32  full word to write
mem_read_data  input  32  combinational read of word at mem_addr

Behaviour:
- Reset: async, rst=1 forces the FSM to IDLE immediately.
  - resp_valid=0, resp_rdata=0, resp_error=0, mem_write_enable=0, mem_addr=0, mem_write_data=0.
  - req_ready=0 while rst is high; req_ready=1 from the first cycle after release.
- FSM states: IDLE, LOAD, RMW_RD, STORE, RESP, ERR.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, funct3, write and wdata.
- Request checks on acceptance:
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010. Goes to ERR.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠00. Goes to ERR.
- Transitions out of IDLE for legal, aligned requests:
  - Load goes to LOAD.
  - SW goes to STORE.
  - SB/SH go to RMW_RD.
- LOAD:
  - mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}, mem_write_enable=0.
  - Select byte addr[1:0] or halfword addr[1]; sign-extend for B/H, zero-extend for BU/HU.
  - Register the result into resp_rdata, then go to RESP.
- RMW_RD:
  - Drive mem_addr as in LOAD, mem_write_enable=0.
  - Capture mem_read_data into a merge register.
  - Replace the addressed byte (wdata[7:0]) or halfword (wdata[15:0]); all other bytes stay unchanged.
  - Go to STORE.
- STORE:
  - mem_addr = word address, mem_write_enable=1 for exactly this cycle.
  - mem_write_data = wdata (SW) or the merged word (SB/SH).
  - Go to RESP.
- RESP: resp_valid=1 for one cycle, resp_error=0, then IDLE.
- ERR:
  - resp_valid=1, resp_error=1, resp_rdata=0, then IDLE.
  - Memory is never accessed; mem_write_enable stays 0.
- Output timing: mem_* outputs are decoded combinationally from the state and latched registers only, never from req_* inputs. Outside LOAD/RMW_RD/STORE, mem_write_enable=0.
- Latency, acceptance edge to the edge where resp_valid is sampled high:
  - Load: 2 cycles. SW: 2 cycles. SB/SH: 3 cycles. Error: 1 cycle.
- No back-to-back acceptance: req_ready=0 from acceptance through RESP/ERR. The earliest next acceptance is the cycle after resp_valid.
- req_* changes while busy are ignored.
- Reset mid-operation:
  - Reset during STORE drops mem_write_enable asynchronously. The write is not guaranteed either way, and the bench must not check it.
  - Reset during LOAD or RMW_RD aborts with no response.
- Address arithmetic: no wrap handling is needed, since accesses never cross a word boundary after the alignment check.

Test Plan:
- Reset: assert rst mid-cycle with req_valid=1 -> resp_valid=0 and mem_write_enable=0 immediately, req_ready=0; after release, req_ready=1.
- SW then LW: SW addr=0x2C data=0xDEADBEEF -> one-cycle mem_write_enable at mem_addr=0x2C with data 0xDEADBEEF, resp_valid 2 cycles after acceptance; LW 0x2C -> resp_rdata=0xDEADBEEF, resp_error=0.
- SB RMW: word 0x2C holds 0x11223344; SB addr=0x2D data=0xAA -> mem_write_data=0x1122AA44, resp_valid 3 cycles after acceptance.
- Loads: LB 0x2D -> 0xFFFFFFAA; LBU 0x2D -> 0x000000AA; LH 0x2E -> 0x00001122; LHU 0x2C -> 0x0000AA44.
- Errors: LW 0x2E, SH 0x2F, funct3=011 load -> each gives resp_valid with resp_error=1 one cycle after acceptance; mem_write_enable never rises and memory is unchanged.
- Handshake: hold req_valid=1 continuously with changing req_addr -> requests are accepted only in IDLE cycles, and each response corresponds to the address latched at acceptance.
